lab5_mcore_mul_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one iterative integer multiplier among p_num_reqs processor cores.
- Each core's datapath issues 64-bit {op0, op1} operand requests and expects a 32-bit product response.
- The block grants one core at a time and remembers the owner while the multiplier computes. It routes the response back only to that owner, then rotates priority.
- Sits between the per-core pipelined datapaths and a single shared multiplier instance.

---
 rtl/lab5_mcore_arb_pkg.sv | 19 +
 rtl/lab5_mcore_rr_arbiter.sv | 41 ++++
 rtl/lab5_mcore_mul_arbiter.sv | 123 ++++++++++++
 tb/tb_lab5_mcore_mul_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lab5_mcore_arb_pkg.sv
// Shared types and sizing helpers for the multi-core multiplier arbiter.
package lab5_mcore_arb_pkg;

    // Sequencer state: IDLE arbitrates, WAIT holds one outstanding transaction.
    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } arb_state_e;

    // Core count of the reference configuration and its owner/prio width.
    localparam int unsigned c_num_reqs    = 32'd4;
    localparam int unsigned c_owner_nbits = $clog2(c_num_reqs);

    // Width of an index over n requesters; never narrower than one bit.
    function automatic int unsigned owner_nbits(input int unsigned n);
        return (n < 32'd2) ? 32'd1 : $clog2(n);
    endfunction

endpackage

// File: rtl/lab5_mcore_rr_arbiter.sv
// Combinational round-robin priority encoder: first asserted request
// starting at prio and wrapping modulo p_nreqs.
module lab5_mcore_rr_arbiter
    import lab5_mcore_arb_pkg::*;
#(
    parameter int unsigned p_nreqs     = 32'd4,
    parameter int unsigned p_idx_nbits = owner_nbits(p_nreqs)
) (
    input  logic [p_nreqs-1:0]     req,
    input  logic [p_idx_nbits-1:0] prio,
    output logic [p_nreqs-1:0]     grant,
    output logic [p_idx_nbits-1:0] grant_idx,
    output logic                   any
);

    int unsigned cand_s;

    // Scan from the priority pointer and latch onto the first requester.
    always_comb begin
        grant     = {p_nreqs{1'b0}};
        grant_idx = {p_idx_nbits{1'b0}};
        any       = 1'b0;
        cand_s    = 32'd0;
        for (int k = 0; k < int'(p_nreqs); k++) begin
            cand_s = int'(prio) + k;
            if (cand_s >= p_nreqs) begin
                cand_s = cand_s - p_nreqs;
            end else begin
                cand_s = cand_s;
            end
            if (!any && req[cand_s]) begin
                any           = 1'b1;
                grant[cand_s] = 1'b1;
                grant_idx     = p_idx_nbits'(cand_s);
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/lab5_mcore_mul_arbiter.sv
// Shares one iterative multiplier among p_num_reqs cores: round-robin grant,
// owner tracking while the multiplier computes, response routed to the owner.
module lab5_mcore_mul_arbiter
    import lab5_mcore_arb_pkg::*;
#(
    parameter int unsigned p_num_reqs   = 32'd4,
    parameter int unsigned p_req_nbits  = 32'd64,
    parameter int unsigned p_resp_nbits = 32'd32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [p_num_reqs-1:0]             req_val,
    output logic [p_num_reqs-1:0]             req_rdy,
    input  logic [p_num_reqs*p_req_nbits-1:0] req_msg,
    output logic [p_num_reqs-1:0]             resp_val,
    input  logic [p_num_reqs-1:0]             resp_rdy,
    output logic [p_resp_nbits-1:0]           resp_msg,
    output logic                              mul_req_val,
    input  logic                              mul_req_rdy,
    output logic [p_req_nbits-1:0]            mul_req_msg,
    input  logic                              mul_resp_val,
    output logic                              mul_resp_rdy,
    input  logic [p_resp_nbits-1:0]           mul_resp_msg
);

    localparam int unsigned c_own_nbits = owner_nbits(p_num_reqs);

    arb_state_e               state_r, state_nxt_s;
    logic [c_own_nbits-1:0]   owner_r, owner_nxt_s;
    logic [c_own_nbits-1:0]   prio_r, prio_nxt_s;
    logic [p_num_reqs-1:0]    grant_s;
    logic [c_own_nbits-1:0]   grant_idx_s;
    logic                     any_s;
    logic                     req_fire_s;
    logic                     resp_fire_s;

    lab5_mcore_rr_arbiter #(
        .p_nreqs     (p_num_reqs),
        .p_idx_nbits (c_own_nbits)
    ) u_rr (
        .req       (req_val),
        .prio      (prio_r),
        .grant     (grant_s),
        .grant_idx (grant_idx_s),
        .any       (any_s)
    );

    assign req_fire_s  = (state_r == IDLE) && any_s && mul_req_rdy;
    assign resp_fire_s = (state_r == WAIT) && mul_resp_val && resp_rdy[owner_r];

    // State, owner and priority pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            owner_r <= {c_own_nbits{1'b0}};
            prio_r  <= {c_own_nbits{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            owner_r <= owner_nxt_s;
            prio_r  <= prio_nxt_s;
        end
    end

    // Next state: capture the winner on issue, rotate priority past it on return.
    always_comb begin
        state_nxt_s = state_r;
        owner_nxt_s = owner_r;
        prio_nxt_s  = prio_r;
        case (state_r)
            IDLE: begin
                if (req_fire_s) begin
                    state_nxt_s = WAIT;
                    owner_nxt_s = grant_idx_s;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            WAIT: begin
                if (resp_fire_s) begin
                    state_nxt_s = IDLE;
                    if (owner_r == c_own_nbits'(p_num_reqs - 32'd1)) begin
                        prio_nxt_s = {c_own_nbits{1'b0}};
                    end else begin
                        prio_nxt_s = owner_r + c_own_nbits'(1);
                    end
                end else begin
                    state_nxt_s = WAIT;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Handshake outputs; all forced low while reset is held.
    always_comb begin
        req_rdy      = {p_num_reqs{1'b0}};
        resp_val     = {p_num_reqs{1'b0}};
        mul_req_val  = 1'b0;
        mul_resp_rdy = 1'b0;
        mul_req_msg  = req_msg[int'(grant_idx_s)*p_req_nbits +: p_req_nbits];
        resp_msg     = mul_resp_msg;
        if (!reset) begin
            req_rdy = {p_num_reqs{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    mul_req_val = any_s;
                    req_rdy     = grant_s & {p_num_reqs{mul_req_rdy}};
                end
                WAIT: begin
                    resp_val[owner_r] = mul_resp_val;
                    mul_resp_rdy      = resp_rdy[owner_r];
                end
                default: begin
                    mul_req_val = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lab5_mcore_mul_arbiter.sv
// Directed bench for the multiplier arbiter with a behavioural multiplier.
module tb_lab5_mcore_mul_arbiter;

    localparam int N  = 4;
    localparam int RQ = 64;
    localparam int RS = 32;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req_val = '0;
    logic [N-1:0]    req_rdy;
    logic [N*RQ-1:0] req_msg = '0;
    logic [N-1:0]    resp_val;
    logic [N-1:0]    resp_rdy = 4'b1111;
    logic [RS-1:0]   resp_msg;
    logic            mul_req_val;
    logic            mul_req_rdy;
    logic [RQ-1:0]   mul_req_msg;
    logic            mul_resp_val;
    logic            mul_resp_rdy;
    logic [RS-1:0]   mul_resp_msg;

    // multiplier model state
    logic            mbusy;
    int              mcnt;
    logic [RS-1:0]   mprod;
    int              mlat = 4;
    logic            mul_rdy_en = 1'b1;
    logic            stray = 1'b0;

    int n_vec = 0;
    int n_err = 0;
    int viol  = 0;
    int grants[$];
    int cyc;
    bit ok;

    lab5_mcore_mul_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req_val      (req_val),
        .req_rdy      (req_rdy),
        .req_msg      (req_msg),
        .resp_val     (resp_val),
        .resp_rdy     (resp_rdy),
        .resp_msg     (resp_msg),
        .mul_req_val  (mul_req_val),
        .mul_req_rdy  (mul_req_rdy),
        .mul_req_msg  (mul_req_msg),
        .mul_resp_val (mul_resp_val),
        .mul_resp_rdy (mul_resp_rdy),
        .mul_resp_msg (mul_resp_msg)
    );

    always #5 clk = ~clk;

    assign mul_req_rdy  = !mbusy && mul_rdy_en;
    assign mul_resp_val = (mbusy && mcnt == 0) || stray;
    assign mul_resp_msg = mprod;

    // Iterative multiplier: mlat cycles after accept, holds result until taken.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mbusy <= 1'b0;
            mcnt  <= 0;
            mprod <= '0;
        end else if (mul_req_val && mul_req_rdy) begin
            mbusy <= 1'b1;
            mcnt  <= mlat;
            mprod <= mul_req_msg[63:32] * mul_req_msg[31:0];
        end else if (mbusy) begin
            if (mcnt != 0) mcnt <= mcnt - 1;
            else if (mul_resp_rdy) mbusy <= 1'b0;
        end
    end

    // Record which core won each issue.
    always @(posedge clk) begin
        if (reset && mul_req_val && mul_req_rdy) begin
            for (int i = 0; i < N; i++) if (req_rdy[i]) grants.push_back(i);
        end
    end

    // No core may see req_rdy while a transaction is outstanding.
    always @(negedge clk) begin
        if (reset && mbusy && req_rdy != '0) viol++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_msg(input int core, input logic [31:0] a, input logic [31:0] b);
        req_msg[core*RQ +: RQ] = {a, b};
    endtask

    task automatic wait_resp(output int c, output bit found);
        found = 1'b0;
        c = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (resp_val != '0) begin
                c = i;
                found = 1'b1;
                break;
            end
        end
    endtask

    initial begin
        // reset state, with requests present to prove output gating
        req_val = 4'b1111;
        #12;
        check("rst_req_rdy", 64'(req_rdy), 64'h0);
        check("rst_resp_val", 64'(resp_val), 64'h0);
        check("rst_mul_req_val", 64'(mul_req_val), 64'h0);
        check("rst_mul_resp_rdy", 64'(mul_resp_rdy), 64'h0);
        req_val = 4'b0000;
        @(negedge clk);
        reset = 1'b1;

        // single core 1, 6*7, latency 4
        @(negedge clk);
        set_msg(1, 32'd6, 32'd7);
        req_val = 4'b0010;
        #1;
        check("t1_req_rdy", 64'(req_rdy), 64'h2);
        check("t1_mul_req_msg", mul_req_msg, {32'd6, 32'd7});
        @(posedge clk); #1 req_val = 4'b0000;
        wait_resp(cyc, ok);
        check("t1_found", 64'(ok), 64'h1);
        check("t1_latency", 64'(cyc), 64'd5);
        check("t1_resp_val", 64'(resp_val), 64'h2);
        check("t1_resp_msg", 64'(resp_msg), 64'd42);
        @(negedge clk);
        req_val = 4'b0101;
        #1;
        check("t1_prio_is_2", 64'(req_rdy), 64'h4);
        req_val = 4'b0000;

        // all four cores, 1-cycle multiplier, from prio 0
        @(negedge clk) reset = 1'b0;
        @(negedge clk) reset = 1'b1;
        mlat = 1;
        grants.delete();
        for (int i = 0; i < N; i++) set_msg(i, 32'(i + 1), 32'd10);
        req_val = 4'b1111;
        for (int i = 0; i < 60 && grants.size() < 5; i++) @(negedge clk);
        req_val = 4'b0000;
        check("t2_n_grants", 64'(grants.size() >= 5), 64'h1);
        for (int i = 0; i < 5 && i < grants.size(); i++)
            check($sformatf("t2_grant%0d", i), 64'(grants[i]), 64'(i % 4));
        for (int i = 0; i < 20 && mbusy; i++) @(negedge clk);

        // owner 2 back-pressures for 5 cycles while core 0 requests (prio=1)
        set_msg(2, 32'd3, 32'd5);
        set_msg(0, 32'd9, 32'd9);
        @(negedge clk);
        resp_rdy = 4'b1011;
        req_val = 4'b0100;
        #1;
        check("t3_req_rdy2", 64'(req_rdy), 64'h4);
        @(posedge clk); #1 req_val = 4'b0001;
        wait_resp(cyc, ok);
        check("t3_found", 64'(ok), 64'h1);
        check("t3_resp_val", 64'(resp_val), 64'h4);
        for (int k = 0; k < 5; k++) begin
            check("t3_stall_mul_resp_rdy", 64'(mul_resp_rdy), 64'h0);
            check("t3_stall_req_rdy", 64'(req_rdy), 64'h0);
            check("t3_stall_resp_msg", 64'(resp_msg), 64'd15);
            @(negedge clk);
        end
        resp_rdy = 4'b1111;
        #1;
        check("t3_accept_mul_resp_rdy", 64'(mul_resp_rdy), 64'h1);
        check("t3_accept_req_rdy", 64'(req_rdy), 64'h0);
        @(negedge clk); #1;
        check("t3_core0_next", 64'(req_rdy), 64'h1);
        req_val = 4'b0000;

        // mul_req_rdy low for 3 cycles with core 3 valid (prio=3)
        set_msg(3, 32'd11, 32'd4);
        @(negedge clk);
        mul_rdy_en = 1'b0;
        req_val = 4'b1000;
        for (int k = 0; k < 3; k++) begin
            #1;
            check("t4_mul_req_val", 64'(mul_req_val), 64'h1);
            check("t4_req_rdy", 64'(req_rdy), 64'h0);
            check("t4_no_fire", 64'(mbusy), 64'h0);
            @(negedge clk);
        end
        mul_rdy_en = 1'b1;
        #1;
        check("t4_req_rdy3", 64'(req_rdy), 64'h8);
        @(posedge clk); #1 req_val = 4'b0000;
        wait_resp(cyc, ok);
        check("t4_resp_val", 64'(resp_val), 64'h8);
        check("t4_resp_msg", 64'(resp_msg), 64'd44);

        // a core 2 transaction moves prio to 3 before the abort test
        @(negedge clk);
        req_val = 4'b0100;
        @(posedge clk); #1 req_val = 4'b0000;
        wait_resp(cyc, ok);
        check("t5_pre_resp_msg", 64'(resp_msg), 64'd15);

        // reset mid-WAIT with owner 1 holding a pending response
        set_msg(1, 32'd2, 32'd20);
        @(negedge clk);
        resp_rdy = 4'b1101;
        req_val = 4'b0010;
        @(posedge clk); #1 req_val = 4'b0000;
        wait_resp(cyc, ok);
        check("t5_resp_val", 64'(resp_val), 64'h2);
        #2;
        req_val = 4'b1010;
        reset = 1'b0;
        #1;
        check("t5_rst_resp_val", 64'(resp_val), 64'h0);
        check("t5_rst_mul_resp_rdy", 64'(mul_resp_rdy), 64'h0);
        check("t5_rst_req_rdy", 64'(req_rdy), 64'h0);
        check("t5_rst_mul_req_val", 64'(mul_req_val), 64'h0);
        @(negedge clk);
        reset = 1'b1;
        resp_rdy = 4'b1111;
        #1;
        check("t5_core1_wins", 64'(req_rdy), 64'h2);
        req_val = 4'b0000;

        // stray multiplier response in IDLE
        @(negedge clk);
        stray = 1'b1;
        #1;
        check("t6_mul_resp_rdy", 64'(mul_resp_rdy), 64'h0);
        check("t6_resp_val", 64'(resp_val), 64'h0);
        @(negedge clk);
        @(negedge clk);
        #1;
        check("t6_mul_resp_rdy_late", 64'(mul_resp_rdy), 64'h0);
        stray = 1'b0;
        req_val = 4'b0001;
        #1;
        check("t6_still_idle", 64'(req_rdy), 64'h1);
        req_val = 4'b0000;

        check("wait_req_rdy_violations", 64'(viol), 64'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
